// File: rtl/shift_rows.sv
// AES ShiftRows / InvShiftRows stage: a pure byte permutation of the 128-bit
// state, registered once, so results appear one cycle after the transfer.
module shift_rows (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic         inv,
    input  logic [127:0] istate,
    output logic [127:0] ostate,
    output logic         out_valid
);

    // Handshake: a transfer happens on every rising edge where in_valid=1.
    // There is no ready, so the stage always accepts. out_valid is high for
    // exactly the cycle after each transfer. On idle edges ostate holds its
    // previous value.

    logic [127:0] fwdState;
    logic [127:0] invState;
    logic [127:0] nextState;

    // Byte k sits at istate[127-8k -: 8] and s(r,c) is byte r+4c.
    // Forward takes s(r,c+r) and inverse takes s(r,c-r), with column indices
    // wrapping modulo 4. All indices are constant after the loops unroll.
    always_comb begin
        fwdState = '0;
        invState = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                fwdState[127 - 8*(r + 4*c) -: 8] =
                    istate[127 - 8*(r + 4*((c + r) % 4)) -: 8];
                invState[127 - 8*(r + 4*c) -: 8] =
                    istate[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
            end
        end
    end

    assign nextState = inv ? invState : fwdState;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ostate    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                ostate <= nextState;
            end
        end
    end

endmodule

// File: tb/tb_shift_rows.sv
// Directed bench for shift_rows: table of known vectors, plus hand-written
// sequences for back-to-back mode switching, reset priority and idle hold.
module tb_shift_rows;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         inv;
    logic [127:0] istate;
    logic [127:0] ostate;
    logic         out_valid;

    int checks = 0;
    int errors = 0;
    logic [127:0] exp_q[$];

    shift_rows dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .inv       (inv),
        .istate    (istate),
        .ostate    (ostate),
        .out_valid (out_valid)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic         inv;
        logic [127:0] st;
        logic [127:0] exp;
    } vec_t;

    // Golden model: gather each row as a 32-bit word, rotate the word, scatter it back.
    function automatic logic [127:0] model(input logic [127:0] s, input logic i);
        logic [127:0] o;
        logic [31:0]  row;
        int           amt;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            row = {s[127 - 8*r -: 8], s[127 - 8*(r + 4) -: 8],
                   s[127 - 8*(r + 8) -: 8], s[127 - 8*(r + 12) -: 8]};
            amt = i ? (32 - 8*r) % 32 : 8*r;
            if (amt != 0) row = (row << amt) | (row >> (32 - amt));
            for (int c = 0; c < 4; c++) o[127 - 8*(r + 4*c) -: 8] = row[31 - 8*c -: 8];
        end
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    // driver: present inputs, take one edge, then settle before sampling
    task automatic drive(input logic v, input logic i, input logic [127:0] st);
        in_valid = v;
        inv      = i;
        istate   = st;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[6];
    logic [127:0] held;
    logic [127:0] x;
    logic [127:0] exp_v;

    initial begin
        vecs[0] = '{"fwd_ref", 1'b0, 128'h11223344_55667788_99AABBCC_DDEEFF00,
                    128'h1166BB00_55AAFF44_99EE3388_DD2277CC};
        vecs[1] = '{"inv_ref", 1'b1, 128'h11223344_55667788_99AABBCC_DDEEFF00,
                    128'h11EEBB88_5522FFCC_99663300_DDAA7744};
        vecs[2] = '{"roundtrip", 1'b1, 128'h1166BB00_55AAFF44_99EE3388_DD2277CC,
                    128'h11223344_55667788_99AABBCC_DDEEFF00};
        vecs[3] = '{"fwd_index", 1'b0, 128'h00010203_04050607_08090A0B_0C0D0E0F,
                    128'h00050A0F_04090E03_080D0207_0C01060B};
        vecs[4] = '{"inv_index", 1'b1, 128'h00010203_04050607_08090A0B_0C0D0E0F,
                    128'h000D0A07_04010E0B_0805020F_0C090603};
        vecs[5] = '{"all_ones", 1'b0, {128{1'b1}}, {128{1'b1}}};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        inv      = 1'b0;
        istate   = '0;
        @(posedge clk);
        #1;
        check128("reset_ostate", ostate, 128'h0);
        check1("reset_valid", out_valid, 1'b0);
        rst_n = 1'b1;

        // table vectors, applied back-to-back
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, vecs[k].inv, vecs[k].st);
            check128(vecs[k].name, ostate, vecs[k].exp);
            check1({vecs[k].name, "_valid"}, out_valid, 1'b1);
        end

        // round trip through the DUT on the result it just produced
        drive(1'b1, 1'b0, 128'h11223344_55667788_99AABBCC_DDEEFF00);
        drive(1'b1, 1'b1, ostate);
        check128("dut_roundtrip", ostate, 128'h11223344_55667788_99AABBCC_DDEEFF00);

        // back-to-back with inv alternating, random states
        for (int k = 0; k < 16; k++) begin
            x = rand128();
            exp_q.push_back(model(x, k[0]));
            drive(1'b1, k[0], x);
            exp_v = exp_q.pop_front();
            check128($sformatf("b2b_%0d", k), ostate, exp_v);
            check1($sformatf("b2b_valid_%0d", k), out_valid, 1'b1);
        end

        // hold: idle cycles with noisy inputs must not disturb the result
        held = ostate;
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, k[0], rand128());
            check128($sformatf("hold_%0d", k), ostate, held);
            check1($sformatf("hold_valid_%0d", k), out_valid, 1'b0);
        end

        // reset takes priority over a presented transfer
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 128'h00010203_04050607_08090A0B_0C0D0E0F);
        check128("rst_prio_ostate", ostate, 128'h0);
        check1("rst_prio_valid", out_valid, 1'b0);
        rst_n = 1'b1;
        x = rand128();
        drive(1'b1, 1'b1, x);
        check128("post_reset", ostate, model(x, 1'b1));
        check1("post_reset_valid", out_valid, 1'b1);
        drive(1'b0, 1'b0, '0);
        check1("post_reset_idle", out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_rows.md
SHIFT_ROWS -- requirements
Module: shift_rows

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The block SHALL use one clock; reset is synchronous and active-low.
REQ-003 Port clk SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n SHALL be an input, 1 bit: synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 Port in_valid SHALL be an input, 1 bit: istate and inv are valid this cycle.
REQ-006 Port inv SHALL be an input, 1 bit: 0 selects ShiftRows, 1 selects InvShiftRows.
REQ-007 Port istate SHALL be an input, 128 bits: the AES state to transform.
REQ-008 Port ostate SHALL be an output, 128 bits: the registered transformed state.
REQ-009 Port out_valid SHALL be an output, 1 bit: ostate holds a new result this cycle.

Function
REQ-010 State mapping SHALL be column-major: byte k = istate[127-8k -: 8], k = 0..15; s(r,c) = byte[r+4c], with r = row 0..3 and c = column 0..3.
REQ-011 With inv=0 (ShiftRows), the result SHALL be s'(r,c) = s(r,(c+r) mod 4): row 0 unchanged, row 1 rotated left 1, row 2 left 2, row 3 left 3.
REQ-012 With inv=1 (InvShiftRows), the result SHALL be s'(r,c) = s(r,(c-r) mod 4): row 1 rotated right 1, row 2 right 2, row 3 right 3.
REQ-013 Operation SHALL be pure byte permutation: no byte value altered, no arithmetic.
REQ-014 Latency SHALL be exactly 1 cycle: in_valid=1 at edge N loads ostate with the result and sets out_valid=1 after edge N.
REQ-015 in_valid=0 at an edge SHALL clear out_valid to 0 and leave ostate holding its previous value.
REQ-016 Back-to-back in_valid=1 cycles SHALL each produce a result; throughput is one state per cycle; there is no backpressure or ready signal.
REQ-017 inv SHALL be sampled per transfer; changing inv between consecutive valid cycles SHALL apply the new mode to the next result only.
REQ-018 InvShiftRows(ShiftRows(x)) = x and ShiftRows(InvShiftRows(x)) = x SHALL hold for all 128-bit x.
REQ-019 X-free behaviour SHALL be required: with rst_n=1 and in_valid=0, ostate SHALL NOT change.

Reset
REQ-020 rst_n=0 at a rising edge SHALL set ostate = 128'h0 and out_valid = 0.
REQ-021 Reset SHALL take priority over in_valid; a transfer presented during a reset cycle SHALL be discarded.
REQ-022 The first valid transfer after rst_n returns to 1 SHALL produce its result with the normal 1-cycle latency.

Verification
REQ-023 Forward: inv=0, istate=11223344_55667788_99AABBCC_DDEEFF00, in_valid=1 -> next cycle ostate=1166BB00_55AAFF44_99EE3388_DD2277CC, out_valid=1.
REQ-024 Inverse: inv=1, same istate -> ostate=11EEBB88_5522FFCC_99663300_DDAA7744, out_valid=1.
REQ-025 Round trip: feed the ostate from REQ-023 back with inv=1 -> ostate=11223344_55667788_99AABBCC_DDEEFF00.
REQ-026 Back-to-back: alternate inv=0/1 over consecutive valid cycles with random states -> each cycle's ostate matches the golden model for its own inv; out_valid stays 1.
REQ-027 Reset: assert rst_n=0 while in_valid=1 -> ostate=0 and out_valid=0 after the edge; release reset, then one valid transfer -> result after 1 cycle.
REQ-028 Hold: in_valid=0 for 5 cycles after a result -> ostate unchanged and out_valid=0.
